cpu_cpu_mult_pipe: RTL

CPU_CPU_MULT_PIPE -- requirements
Module: cpu_cpu_mult_pipe

---
 rtl/cpu_cpu_mult_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_cpu_mult_pipe.sv
// rtl/cpu_cpu_mult_pipe.sv - two-stage split-operand multiplier, optional output register.
// Define CPU_MULT_HI_EN to build the hi*hi product and the upper result half.
module cpu_cpu_mult_pipe #(
   parameter int DATA_W  = 32,
   parameter int OUT_REG = 0,
   parameter int TAG_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              M_en,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] E_src1,
   input  logic [DATA_W-1:0] E_src2,
   input  logic              src1_signed,
   input  logic              src2_signed,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   output logic [DATA_W-1:0] result_lo,
   output logic [DATA_W-1:0] result_hi,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int H  = DATA_W / 2;
   localparam int W2 = 2 * DATA_W;
`ifdef CPU_MULT_HI_EN
   localparam int PW = DATA_W;
`else
   // Only the low H bits of the cross products can reach result_lo.
   localparam int PW = H;
`endif

   logic              s1_valid_q, s1_valid_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
   logic [DATA_W-1:0] s1_ll_q, s1_ll_d;
   logic [PW-1:0]     s1_lh_q, s1_lh_d;
   logic [PW-1:0]     s1_hl_q, s1_hl_d;
`ifdef CPU_MULT_HI_EN
   logic [DATA_W-1:0] s1_hh_q, s1_hh_d;
   logic [DATA_W-1:0] s1_corr_q, s1_corr_d;
   logic              a_neg, b_neg;
   logic [W2-1:0]     prod_full;

   assign a_neg = src1_signed & E_src1[DATA_W-1];
   assign b_neg = src2_signed & E_src2[DATA_W-1];
`endif

   logic              s2_valid_q, s2_valid_d;
   logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
   logic [DATA_W-1:0] s2_lo_q, s2_lo_d;
   logic [DATA_W-1:0] s2_hi_q, s2_hi_d;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_tag_d   = s1_tag_q;
      s1_ll_d    = s1_ll_q;
      s1_lh_d    = s1_lh_q;
      s1_hl_d    = s1_hl_q;
`ifdef CPU_MULT_HI_EN
      s1_hh_d    = s1_hh_q;
      s1_corr_d  = s1_corr_q;
`endif
      if (M_en) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_tag_d = in_tag;
            s1_ll_d  = DATA_W'(E_src1[H-1:0]) * DATA_W'(E_src2[H-1:0]);
            s1_lh_d  = PW'(E_src1[H-1:0]) * PW'(E_src2[DATA_W-1:H]);
            s1_hl_d  = PW'(E_src1[DATA_W-1:H]) * PW'(E_src2[H-1:0]);
`ifdef CPU_MULT_HI_EN
            s1_hh_d  = DATA_W'(E_src1[DATA_W-1:H]) * DATA_W'(E_src2[DATA_W-1:H]);
            // Signed correction only touches the upper half modulo 2^(2*DATA_W).
            s1_corr_d = (a_neg ? E_src2 : '0) + (b_neg ? E_src1 : '0);
`endif
         end
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_tag_d   = s2_tag_q;
      s2_lo_d    = s2_lo_q;
      s2_hi_d    = s2_hi_q;
`ifdef CPU_MULT_HI_EN
      prod_full = W2'(s1_ll_q) + (W2'(s1_lh_q) << H) + (W2'(s1_hl_q) << H)
                + {s1_hh_q, {DATA_W{1'b0}}} - {s1_corr_q, {DATA_W{1'b0}}};
`endif
      if (M_en) begin
         s2_valid_d = s1_valid_q;
         // Result registers only load on valid so bubbles keep the last result.
         if (s1_valid_q) begin
            s2_tag_d = s1_tag_q;
`ifdef CPU_MULT_HI_EN
            s2_lo_d  = prod_full[DATA_W-1:0];
            s2_hi_d  = prod_full[W2-1:DATA_W];
`else
            s2_lo_d  = s1_ll_q + {s1_lh_q, {H{1'b0}}} + {s1_hl_q, {H{1'b0}}};
            s2_hi_d  = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_tag_q   <= '0;
         s1_ll_q    <= '0;
         s1_lh_q    <= '0;
         s1_hl_q    <= '0;
`ifdef CPU_MULT_HI_EN
         s1_hh_q    <= '0;
         s1_corr_q  <= '0;
`endif
         s2_valid_q <= 1'b0;
         s2_tag_q   <= '0;
         s2_lo_q    <= '0;
         s2_hi_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         s1_ll_q    <= s1_ll_d;
         s1_lh_q    <= s1_lh_d;
         s1_hl_q    <= s1_hl_d;
`ifdef CPU_MULT_HI_EN
         s1_hh_q    <= s1_hh_d;
         s1_corr_q  <= s1_corr_d;
`endif
         s2_valid_q <= s2_valid_d;
         s2_tag_q   <= s2_tag_d;
         s2_lo_q    <= s2_lo_d;
         s2_hi_q    <= s2_hi_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic              o_valid_q, o_valid_d;
         logic [TAG_W-1:0]  o_tag_q, o_tag_d;
         logic [DATA_W-1:0] o_lo_q, o_lo_d;
         logic [DATA_W-1:0] o_hi_q, o_hi_d;

         always_comb begin
            o_valid_d = o_valid_q;
            o_tag_d   = o_tag_q;
            o_lo_d    = o_lo_q;
            o_hi_d    = o_hi_q;
            if (M_en) begin
               o_valid_d = s2_valid_q;
               if (s2_valid_q) begin
                  o_tag_d = s2_tag_q;
                  o_lo_d  = s2_lo_q;
                  o_hi_d  = s2_hi_q;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               o_valid_q <= 1'b0;
               o_tag_q   <= '0;
               o_lo_q    <= '0;
               o_hi_q    <= '0;
            end else begin
               o_valid_q <= o_valid_d;
               o_tag_q   <= o_tag_d;
               o_lo_q    <= o_lo_d;
               o_hi_q    <= o_hi_d;
            end
         end

         assign out_valid = o_valid_q;
         assign out_tag   = o_tag_q;
         assign result_lo = o_lo_q;
         assign result_hi = o_hi_q;
      end else begin : g_no_out_reg
         assign out_valid = s2_valid_q;
         assign out_tag   = s2_tag_q;
         assign result_lo = s2_lo_q;
         assign result_hi = s2_hi_q;
      end
   endgenerate

endmodule
